fifo_ctrl_thr: RTL and testbench
================================

# fifo_ctrl_thr

Parametrised synchronous FIFO controller with show-ahead read, programmable almost-full/almost-empty watermarks, occupancy output and sticky overflow/underflow error flags. It supersedes the basic FIFO controller wherever producers need back-pressure before the FIFO is completely full. Typical users are stream buffers between DMA and packet engines. It also serves as the DUT for assume-guarantee abstraction proofs on FIFO occupancy.

## Interface
- DEPTH, 8: number of entries; any value ≥2, not restricted to powers of two
- WIDTH, 32: data width in bits
- CNTWD, $clog2(DEPTH+1): width of occupancy and watermark values (derived; do not override)
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- push_req  in  1  write request
- push_ack  out  1  space available; the write is taken this cycle when push_req && push_ack
- data_in  in  WIDTH  write data
- pop_req  in  1  read request
- pop_ack  out  1  data available; the read is taken this cycle when pop_req && pop_ack
- data_out  out  WIDTH  head entry (show-ahead); valid while pop_ack=1
- afull_lvl  in  CNTWD  almost-full watermark, quasi-static
- aempty_lvl  in  CNTWD  almost-empty watermark, quasi-static
- count  out  CNTWD  current occupancy
- almost_full  out  1  count ≥ afull_lvl
- almost_empty  out  1  count ≤ aempty_lvl
- err_ovf  out  1  sticky: push_req seen while full
- err_udf  out  1  sticky: pop_req seen while empty
- err_clr  in  1  synchronous clear of both sticky flags

## Operation
- Internal state: wptr and rptr (each $clog2(DEPTH) bits), count register (CNTWD bits), memory array of DEPTH×WIDTH (not reset).
- Flag definitions:
  - full = (count == DEPTH); empty = (count == 0)
  - push_ack = ~full; pop_ack = ~empty
  - wr = push_req & ~full; rd = pop_req & ~empty
- Pointers advance by 1 on wr/rd and wrap from DEPTH-1 to 0; the wrap is explicit and does not rely on natural overflow.
- Write: mem[wptr] <= data_in on wr.
- Read: data_out = mem[rptr] combinationally.
- Count update: count <= count + wr - rd, evaluated at CNTWD+1 bits. It never exceeds DEPTH and never goes below 0.
- Simultaneous wr and rd:
  - count unchanged, both pointers advance
  - When empty, a push is written but cannot be popped in the same cycle (no bypass).
  - When full, a pop succeeds but the push is refused (no fall-through). err_ovf is set.
- Watermark compare is unsigned.
  - afull_lvl=0 forces almost_full=1.
  - afull_lvl > DEPTH forces almost_full=0.
  - aempty_lvl ≥ DEPTH forces almost_empty=1.
- Error flags:
  - err_ovf sets on push_req & full.
  - err_udf sets on pop_req & empty.
  - err_clr clears both flags; a set condition in the same cycle wins over the clear.
- Refused requests never modify pointers, count or memory.

## Timing
- Reset values: push_ack=1, pop_ack=0, count=0, almost_full=(afull_lvl==0), almost_empty=1, err_ovf=0, err_udf=0. data_out is undefined (memory not reset).
- Reset asserted mid-operation clears pointers, count and flags immediately (asynchronous). FIFO contents are logically discarded.
- Write-to-read latency: an entry pushed at edge N is visible on data_out with pop_ack=1 after edge N, i.e. one cycle later.
- All outputs except data_out are functions of registered state only; data_out also depends on rptr. There is no combinational path from request inputs to any output.
- count, almost_full, almost_empty and push_ack/pop_ack update together on the same edge.
- Error flags assert the cycle after the offending request.

## Configuration
- FIFO_CTRL_ERR_EN:
  - Defined: err_ovf/err_udf sticky logic is present and err_clr is honoured.
  - Undefined: both error outputs are tied to 0, err_clr is ignored, and the flag registers are absent.
- The port list is identical in both builds.

## Structure
- Package fifo_ctrl_pkg holds:
  - function ptr_inc(ptr, depth), wrap-aware increment
  - localparam helpers for PTRWD/CNTWD derivation
  - typedef for the error-flag struct {ovf, udf}
- Sub-module fifo_ctrl_ptr: one wrap-around pointer with enable and asynchronous reset, instantiated twice (write and read).
- Memory, count, watermark and error logic live in the top level.

## Test plan
- Reset, then DEPTH=6: push 6 words 0xA0..0xA5 → count=6, push_ack=0, almost_full=1 with afull_lvl=5. Pop 6 → data_out returns 0xA0..0xA5 in order, then pop_ack=0.
- Wrap, DEPTH=6: 20 cycles of interleaved push/pop with count held at 3 → pointers wrap past 5 to 0 and data order is preserved.
- Full plus simultaneous push/pop → pop returns the head, push is refused, count drops to 5, err_ovf=1 next cycle. err_clr pulse → err_ovf=0.
- Empty plus push/pop same cycle → push written, pop refused, count=1, err_udf=1. Next cycle pop_ack=1 and data_out=pushed value.
- Watermarks with aempty_lvl=1, afull_lvl=4 → almost_empty=1 at counts 0–1, almost_full=1 at counts 4–6, transitions exactly at the edge where count changes.
- resetn pulsed low with count=4 → count=0, pop_ack=0 and error flags 0 immediately. Subsequent push/pop behaves as from a fresh reset.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the threshold FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

  // Index arithmetic is done at this fixed width and then cast down, so one
  // increment helper can serve pointers of any parameterised width.
  localparam int unsigned IDX_MAXW = 32;

  // Pointer width; never zero even for the smallest legal depth.
  function automatic int unsigned ptrwd_f(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must hold the value DEPTH itself, hence depth+1.
  function automatic int unsigned cntwd_f(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic ovf;
    logic udf;
  } err_flags_t;

  // Explicit wrap at depth-1 so non-power-of-two depths work.
  function automatic logic [IDX_MAXW-1:0] ptr_inc(input logic [IDX_MAXW-1:0] ptr,
                                                  input logic [IDX_MAXW-1:0] depth);
    return (ptr == depth - 1) ? '0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrap-around FIFO pointer: advances by one when enabled, 0 after DEPTH-1.
// Latency: new value visible one cycle after en_i.
// Backpressure: none; the caller qualifies en_i.
// Ports: clk, resetn (async active-low), en_i (advance), ptr_o (current index).
module fifo_ctrl_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTRWD = ptrwd_f(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  output logic [PTRWD-1:0] ptr_o
);

  logic [PTRWD-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = PTRWD'(ptr_inc(IDX_MAXW'(ptr_q), IDX_MAXW'(DEPTH)));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_thr.sv
// Show-ahead synchronous FIFO with almost-full/almost-empty watermarks and sticky error flags.
// Latency: a push at edge N is on data_out (pop_ack=1) after edge N; no bypass when empty.
// Backpressure: push_ack=~full, pop_ack=~empty; refused requests change nothing.
// Ports: clk, resetn; push_req/push_ack/data_in; pop_req/pop_ack/data_out;
//        afull_lvl/aempty_lvl (watermarks), count, almost_full, almost_empty;
//        err_ovf/err_udf (sticky), err_clr.
// Build option: define FIFO_CTRL_ERR_EN to include the sticky error flags;
//        otherwise err_ovf/err_udf read 0 and err_clr is ignored.
module fifo_ctrl_thr
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTWD = cntwd_f(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_req,
  output logic             push_ack,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_req,
  output logic             pop_ack,
  output logic [WIDTH-1:0] data_out,
  input  logic [CNTWD-1:0] afull_lvl,
  input  logic [CNTWD-1:0] aempty_lvl,
  output logic [CNTWD-1:0] count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             err_ovf,
  output logic             err_udf,
  input  logic             err_clr
);

  localparam int unsigned      PTRWD   = ptrwd_f(DEPTH);
  localparam logic [CNTWD-1:0] DEPTH_C = CNTWD'(DEPTH);
  localparam logic [CNTWD:0]   ONE_X   = (CNTWD+1)'(1);

  logic [CNTWD-1:0] count_q, count_d;
  logic [CNTWD:0]   cnt_ext;
  logic [PTRWD-1:0] wptr, rptr;
  logic             full, empty, wr, rd;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Flags come from the registered count only, so no request input reaches
  // any output combinationally.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign wr    = push_req & ~full;
  assign rd    = pop_req & ~empty;

  fifo_ctrl_ptr #(.DEPTH(DEPTH), .PTRWD(PTRWD)) u_wptr (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (wr),
    .ptr_o  (wptr)
  );

  fifo_ctrl_ptr #(.DEPTH(DEPTH), .PTRWD(PTRWD)) u_rptr (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (rd),
    .ptr_o  (rptr)
  );

  // Storage is deliberately not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr] <= data_in;
    end
  end

  assign data_out = mem_q[rptr];

  // One extra bit of headroom for the +/-1 step; wr/rd gating keeps the
  // result inside 0..DEPTH.
  always_comb begin
    cnt_ext = {1'b0, count_q};
    if (wr && !rd) begin
      cnt_ext = cnt_ext + ONE_X;
    end else if (rd && !wr) begin
      cnt_ext = cnt_ext - ONE_X;
    end
    count_d = cnt_ext[CNTWD-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign push_ack = ~full;
  assign pop_ack  = ~empty;

  // Plain unsigned compares already give the corner cases: a level of 0
  // always reads almost-full, a level above DEPTH never does, and an
  // almost-empty level at or above DEPTH always reads almost-empty.
  assign almost_full  = (count_q >= afull_lvl);
  assign almost_empty = (count_q <= aempty_lvl);

`ifdef FIFO_CTRL_ERR_EN
  err_flags_t err_q, err_d;

  // Clear first, then set, so an offending request in the clear cycle wins.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end
    if (push_req && full) begin
      err_d.ovf = 1'b1;
    end
    if (pop_req && empty) begin
      err_d.udf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_ovf = err_q.ovf;
  assign err_udf = err_q.udf;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_thr.sv
// Directed bench for fifo_ctrl_thr at DEPTH=6, WIDTH=8.
// Latency: vectors drive on the falling edge and check 1 time unit after the rising edge.
// Backpressure: exercised via full/empty corner rows.
module tb_fifo_ctrl_thr;

  localparam int DEPTH = 6;
  localparam int WIDTH = 8;
  localparam int CNTWD = 3;
`ifdef FIFO_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             push_req, pop_req, err_clr;
  logic             push_ack, pop_ack;
  logic [WIDTH-1:0] data_in, data_out;
  logic [CNTWD-1:0] afull_lvl, aempty_lvl, count;
  logic             almost_full, almost_empty, err_ovf, err_udf;

  always #5 clk = ~clk;

  fifo_ctrl_thr #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .push_req     (push_req),
    .push_ack     (push_ack),
    .data_in      (data_in),
    .pop_req      (pop_req),
    .pop_ack      (pop_ack),
    .data_out     (data_out),
    .afull_lvl    (afull_lvl),
    .aempty_lvl   (aempty_lvl),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_ovf      (err_ovf),
    .err_udf      (err_udf),
    .err_clr      (err_clr)
  );

  typedef struct {
    logic       push, pop, clr;
    logic [7:0] din;
    logic [2:0] afl, ael;
    logic [2:0] cnt;
    logic       pa, pp, af, ae, chk;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   checks = 0;
  int   failures = 0;

  // Error expectations are written as if the flags exist; they are masked
  // when the build leaves them out.
  task automatic add(input int p, input int po, input int c, input int d,
                     input int afl, input int ael, input int cnt, input int pa,
                     input int pp, input int af, input int ae, input int chk,
                     input int dout, input int ovf, input int udf);
    vecs[nvec].push = p[0];
    vecs[nvec].pop  = po[0];
    vecs[nvec].clr  = c[0];
    vecs[nvec].din  = d[7:0];
    vecs[nvec].afl  = afl[2:0];
    vecs[nvec].ael  = ael[2:0];
    vecs[nvec].cnt  = cnt[2:0];
    vecs[nvec].pa   = pa[0];
    vecs[nvec].pp   = pp[0];
    vecs[nvec].af   = af[0];
    vecs[nvec].ae   = ae[0];
    vecs[nvec].chk  = chk[0];
    vecs[nvec].dout = dout[7:0];
    vecs[nvec].ovf  = ovf[0];
    vecs[nvec].udf  = udf[0];
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] cnt, input logic pa,
                             input logic pp, input logic af, input logic ae,
                             input logic chk, input logic [7:0] dout,
                             input logic ovf, input logic udf);
    check({tag, " count"}, 32'(count), 32'(cnt));
    check({tag, " push_ack"}, 32'(push_ack), 32'(pa));
    check({tag, " pop_ack"}, 32'(pop_ack), 32'(pp));
    check({tag, " almost_full"}, 32'(almost_full), 32'(af));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
    check({tag, " err_ovf"}, 32'(err_ovf), 32'(ovf & ERR_EN));
    check({tag, " err_udf"}, 32'(err_udf), 32'(udf & ERR_EN));
    if (chk) check({tag, " data_out"}, 32'(data_out), 32'(dout));
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      push_req   = vecs[i].push;
      pop_req    = vecs[i].pop;
      err_clr    = vecs[i].clr;
      data_in    = vecs[i].din;
      afull_lvl  = vecs[i].afl;
      aempty_lvl = vecs[i].ael;
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pa, vecs[i].pp,
                  vecs[i].af, vecs[i].ae, vecs[i].chk, vecs[i].dout,
                  vecs[i].ovf, vecs[i].udf);
    end
  endtask

  task automatic idle_inputs();
    push_req = 1'b0;
    pop_req  = 1'b0;
    err_clr  = 1'b0;
    data_in  = '0;
  endtask

  int a_end, b_end, c_end;
  logic [7:0] exp_head;

  initial begin
    //  push pop clr din   afl ael | cnt pa pp af ae chk dout ovf udf
    // Fill 0xA0..0xA5 then drain.
    add(1,0,0,'hA0, 5,1, 1,1,1,0,1,1,'hA0, 0,0);
    add(1,0,0,'hA1, 5,1, 2,1,1,0,0,1,'hA0, 0,0);
    add(1,0,0,'hA2, 5,1, 3,1,1,0,0,1,'hA0, 0,0);
    add(1,0,0,'hA3, 5,1, 4,1,1,0,0,1,'hA0, 0,0);
    add(1,0,0,'hA4, 5,1, 5,1,1,1,0,1,'hA0, 0,0);
    add(1,0,0,'hA5, 5,1, 6,0,1,1,0,1,'hA0, 0,0);
    add(0,1,0,'h00, 5,1, 5,1,1,1,0,1,'hA1, 0,0);
    add(0,1,0,'h00, 5,1, 4,1,1,0,0,1,'hA2, 0,0);
    add(0,1,0,'h00, 5,1, 3,1,1,0,0,1,'hA3, 0,0);
    add(0,1,0,'h00, 5,1, 2,1,1,0,0,1,'hA4, 0,0);
    add(0,1,0,'h00, 5,1, 1,1,1,0,1,1,'hA5, 0,0);
    add(0,1,0,'h00, 5,1, 0,1,0,0,1,0,'h00, 0,0);
    // Empty: push taken, pop refused, underflow flagged; then clear.
    add(1,1,0,'hB7, 5,1, 1,1,1,0,1,1,'hB7, 0,1);
    add(0,0,1,'h00, 5,1, 1,1,1,0,1,1,'hB7, 0,0);
    add(1,0,0,'hC1, 5,1, 2,1,1,0,0,1,'hB7, 0,0);
    add(1,0,0,'hC2, 5,1, 3,1,1,0,0,1,'hB7, 0,0);
    add(1,0,0,'hC3, 5,1, 4,1,1,0,0,1,'hB7, 0,0);
    add(1,0,0,'hC4, 5,1, 5,1,1,1,0,1,'hB7, 0,0);
    add(1,0,0,'hC5, 5,1, 6,0,1,1,0,1,'hB7, 0,0);
    // Full: pop taken, push refused, overflow flagged; clear; set beats clear.
    add(1,1,0,'hD0, 5,1, 5,1,1,1,0,1,'hC1, 1,0);
    add(0,0,1,'h00, 5,1, 5,1,1,1,0,1,'hC1, 0,0);
    add(1,0,1,'hC6, 5,1, 6,0,1,1,0,1,'hC1, 0,0);
    add(1,0,1,'hE0, 5,1, 6,0,1,1,0,1,'hC1, 1,0);
    add(0,1,0,'h00, 5,1, 5,1,1,1,0,1,'hC2, 1,0);
    add(0,1,0,'h00, 5,1, 4,1,1,0,0,1,'hC3, 1,0);
    add(0,1,0,'h00, 5,1, 3,1,1,0,0,1,'hC4, 1,0);
    a_end = nvec;
    // Watermarks afull=4, aempty=1 after the wrap run (contents 71,72,73).
    add(0,0,0,'h00, 4,1, 3,1,1,0,0,1,'h71, 1,0);
    add(0,1,0,'h00, 4,1, 2,1,1,0,0,1,'h72, 1,0);
    add(0,1,0,'h00, 4,1, 1,1,1,0,1,1,'h73, 1,0);
    add(0,1,0,'h00, 4,1, 0,1,0,0,1,0,'h00, 1,0);
    add(1,0,0,'h90, 4,1, 1,1,1,0,1,1,'h90, 1,0);
    add(1,0,0,'h91, 4,1, 2,1,1,0,0,1,'h90, 1,0);
    add(1,0,0,'h92, 4,1, 3,1,1,0,0,1,'h90, 1,0);
    add(1,0,0,'h93, 4,1, 4,1,1,1,0,1,'h90, 1,0);
    add(1,0,0,'h94, 4,1, 5,1,1,1,0,1,'h90, 1,0);
    add(1,0,0,'h95, 4,1, 6,0,1,1,0,1,'h90, 1,0);
    // Level extremes: afull above DEPTH, aempty at DEPTH, then both zero.
    add(0,0,0,'h00, 7,6, 6,0,1,0,1,1,'h90, 1,0);
    add(0,0,0,'h00, 0,0, 6,0,1,1,0,1,'h90, 1,0);
    add(0,1,0,'h00, 4,1, 5,1,1,1,0,1,'h91, 1,0);
    add(0,1,0,'h00, 4,1, 4,1,1,1,0,1,'h92, 1,0);
    b_end = nvec;
    // After a mid-operation reset the FIFO behaves as fresh.
    add(1,0,0,'h5A, 4,1, 1,1,1,0,1,1,'h5A, 0,0);
    add(0,1,0,'h00, 4,1, 0,1,0,0,1,0,'h00, 0,0);
    c_end = nvec;

    // Power-on reset.
    idle_inputs();
    afull_lvl  = 3'd5;
    aempty_lvl = 3'd1;
    resetn     = 1'b0;
    #12;
    check_state("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    afull_lvl = 3'd0;
    #1;
    check("reset almost_full lvl0", 32'(almost_full), 32'd1);
    afull_lvl = 3'd5;
    @(negedge clk);
    resetn = 1'b1;

    run_vectors(0, a_end);

    // Wrap: 20 simultaneous push/pop at count 3 starting from C4,C5,C6.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      push_req = 1'b1;
      pop_req  = 1'b1;
      err_clr  = 1'b0;
      data_in  = 8'(8'h60 + k);
      @(posedge clk);
      #1;
      if (k == 0)      exp_head = 8'hC5;
      else if (k == 1) exp_head = 8'hC6;
      else             exp_head = 8'(8'h60 + k - 2);
      check($sformatf("wrap%0d count", k), 32'(count), 32'd3);
      check($sformatf("wrap%0d data_out", k), 32'(data_out), 32'(exp_head));
    end

    run_vectors(a_end, b_end);

    // Asynchronous reset with count=4 and overflow flag still set.
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    #1;
    check_state("midreset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    resetn = 1'b1;

    run_vectors(b_end, c_end);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
